// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit between the EX/MEM register and the data bus
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   ex_mem_*               operation from the EX/MEM register, held stable while mem_stall_o=1
//   dbus_req/we/addr/be/wdata_o   data bus request, driven from the inputs in the request cycle
//                                 and from captured copies while waiting for the grant
//   dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i   bus grant and response
//   mem_stall_o            freezes the upstream pipeline while a bus access is outstanding
//   mem_misaligned_o       single-cycle pulse for a misaligned access (no bus request issued)
//   wb_data/waddr/we_o     registered writeback to the register file
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ex_mem_op_c_i,
  input  logic [4:0]  ex_mem_reg_waddr_i,
  input  logic        ex_mem_reg_we_i,
  input  logic        ex_mem_mem_re_i,
  input  logic        ex_mem_mem_we_i,
  input  logic [31:0] ex_mem_wdata_i,
  input  logic [1:0]  ex_mem_size_i,
  input  logic        ex_mem_unsigned_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        mem_stall_o,
  output logic        mem_misaligned_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_waddr_o,
  output logic        wb_we_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        store_q;
  logic        we_q;
  logic [4:0]  waddr_q;

  logic        mem_op;
  logic        store_in;
  logic        misaligned_in;
  logic [31:0] rshift;
  logic [31:0] load_data;

  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   be_of = 4'b0001 << off;
      2'b01:   be_of = off[1] ? 4'b1100 : 4'b0011;
      default: be_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lanes_of(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   lanes_of = {4{wd[7:0]}};
      2'b01:   lanes_of = {2{wd[15:0]}};
      default: lanes_of = wd;
    endcase
  endfunction

  // A load with both enables set still counts as a load, so store only when re is clear.
  assign mem_op   = ex_mem_mem_re_i | ex_mem_mem_we_i;
  assign store_in = ex_mem_mem_we_i & ~ex_mem_mem_re_i;

  always_comb begin
    misaligned_in = 1'b0;
    case (ex_mem_size_i)
      2'b00:   misaligned_in = 1'b0;
      2'b01:   misaligned_in = ex_mem_op_c_i[0];
      default: misaligned_in = |ex_mem_op_c_i[1:0];
    endcase
  end

  // Bring the addressed byte lane down to bit 0 before extension.
  assign rshift = dbus_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = rshift;
    case (size_q)
      2'b00:   load_data = {{24{~unsigned_q & rshift[7]}}, rshift[7:0]};
      2'b01:   load_data = {{16{~unsigned_q & rshift[15]}}, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    dbus_req_o       = 1'b0;
    dbus_we_o        = 1'b0;
    dbus_addr_o      = 32'h0;
    dbus_be_o        = 4'h0;
    dbus_wdata_o     = 32'h0;
    mem_stall_o      = 1'b0;
    mem_misaligned_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (misaligned_in) begin
            mem_misaligned_o = 1'b1;
          end else begin
            dbus_req_o   = 1'b1;
            dbus_we_o    = store_in;
            dbus_addr_o  = {ex_mem_op_c_i[31:2], 2'b00};
            dbus_be_o    = be_of(ex_mem_size_i, ex_mem_op_c_i[1:0]);
            dbus_wdata_o = lanes_of(ex_mem_size_i, ex_mem_wdata_i);
            mem_stall_o  = 1'b1;
            state_d      = dbus_gnt_i ? WAIT : REQ;
          end
        end
      end
      REQ: begin
        dbus_req_o   = 1'b1;
        dbus_we_o    = store_q;
        dbus_addr_o  = {addr_q[31:2], 2'b00};
        dbus_be_o    = be_of(size_q, addr_q[1:0]);
        dbus_wdata_o = lanes_of(size_q, wdata_q);
        mem_stall_o  = 1'b1;
        // A response arriving with the grant is not ours yet; only the grant counts.
        if (dbus_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        mem_stall_o = ~dbus_rvalid_i;
        if (dbus_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset silences every output at once, even while the inputs still request an access.
    if (!rst_n) begin
      dbus_req_o       = 1'b0;
      dbus_we_o        = 1'b0;
      dbus_addr_o      = 32'h0;
      dbus_be_o        = 4'h0;
      dbus_wdata_o     = 32'h0;
      mem_stall_o      = 1'b0;
      mem_misaligned_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      store_q    <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= 5'h0;
    end else if (state_q == IDLE && mem_op && !misaligned_in) begin
      addr_q     <= ex_mem_op_c_i;
      wdata_q    <= ex_mem_wdata_i;
      size_q     <= ex_mem_size_i;
      unsigned_q <= ex_mem_unsigned_i;
      store_q    <= store_in;
      we_q       <= ex_mem_reg_we_i;
      waddr_q    <= ex_mem_reg_waddr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data_o  <= 32'h0;
      wb_waddr_o <= 5'h0;
      wb_we_o    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!mem_op) begin
            wb_data_o  <= ex_mem_op_c_i;
            wb_waddr_o <= ex_mem_reg_waddr_i;
            wb_we_o    <= ex_mem_reg_we_i;
          end else begin
            wb_we_o    <= 1'b0;
          end
        end
        WAIT: begin
          if (dbus_rvalid_i && !store_q) begin
            wb_data_o  <= load_data;
            wb_waddr_o <= waddr_q;
            wb_we_o    <= we_q;
          end else begin
            wb_we_o    <= 1'b0;
          end
        end
        default: wb_we_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ex_mem_op_c_i = 32'h0;
  logic [4:0]  ex_mem_reg_waddr_i = 5'h0;
  logic        ex_mem_reg_we_i = 1'b0;
  logic        ex_mem_mem_re_i = 1'b0;
  logic        ex_mem_mem_we_i = 1'b0;
  logic [31:0] ex_mem_wdata_i = 32'h0;
  logic [1:0]  ex_mem_size_i = 2'b00;
  logic        ex_mem_unsigned_i = 1'b0;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i = 1'b0;
  logic        dbus_rvalid_i = 1'b0;
  logic [31:0] dbus_rdata_i = 32'h0;
  logic        mem_stall_o, mem_misaligned_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_waddr_o;
  logic        wb_we_o;

  int checks = 0;
  int failures = 0;
  int req_cnt = 0;
  int stall_cnt = 0;
  int mis_cnt = 0;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ex_mem_op_c_i(ex_mem_op_c_i), .ex_mem_reg_waddr_i(ex_mem_reg_waddr_i),
    .ex_mem_reg_we_i(ex_mem_reg_we_i), .ex_mem_mem_re_i(ex_mem_mem_re_i),
    .ex_mem_mem_we_i(ex_mem_mem_we_i), .ex_mem_wdata_i(ex_mem_wdata_i),
    .ex_mem_size_i(ex_mem_size_i), .ex_mem_unsigned_i(ex_mem_unsigned_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(dbus_gnt_i),
    .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
    .mem_stall_o(mem_stall_o), .mem_misaligned_o(mem_misaligned_o),
    .wb_data_o(wb_data_o), .wb_waddr_o(wb_waddr_o), .wb_we_o(wb_we_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int unsigned nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic is_mis(input logic [1:0] size, input logic [31:0] a);
    return (a % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] a);
    logic [3:0] b = 4'h0;
    int unsigned off = 32'(a[1:0]);
    for (int unsigned i = 0; i < nbytes(size); i++) b[off + i] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] m_lanes(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'b00) return {24'h0, wd[7:0]} * 32'h01010101;
    if (size == 2'b01) return {16'h0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_extract(input logic [31:0] rd, input logic [31:0] a,
                                            input logic [1:0] size, input logic uns);
    logic [31:0] v = rd >> (8 * 32'(a[1:0]));
    int unsigned n = nbytes(size);
    if (n == 4) return v;
    v = v & ((32'h1 << (8 * n)) - 32'h1);
    if (!uns && ((v >> (8 * n - 1)) & 32'h1) != 0) v = v - (32'h1 << (8 * n));
    return v;
  endfunction

  logic        m_await_gnt = 1'b0, m_await_rsp = 1'b0;
  logic [31:0] t_addr = 32'h0, t_wdata = 32'h0;
  logic [1:0]  t_size = 2'b00;
  logic        t_uns = 1'b0, t_store = 1'b0, t_we = 1'b0;
  logic [4:0]  t_waddr = 5'h0;
  logic [31:0] e_wb_data = 32'h0;
  logic [4:0]  e_wb_waddr = 5'h0;
  logic        e_wb_we = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_await_gnt <= 1'b0; m_await_rsp <= 1'b0;
      e_wb_data <= 32'h0; e_wb_waddr <= 5'h0; e_wb_we <= 1'b0;
    end else if (m_await_rsp) begin
      e_wb_we <= 1'b0;
      if (dbus_rvalid_i) begin
        m_await_rsp <= 1'b0;
        if (!t_store) begin
          e_wb_data  <= m_extract(dbus_rdata_i, t_addr, t_size, t_uns);
          e_wb_waddr <= t_waddr;
          e_wb_we    <= t_we;
        end
      end
    end else if (m_await_gnt) begin
      e_wb_we <= 1'b0;
      if (dbus_gnt_i) begin m_await_gnt <= 1'b0; m_await_rsp <= 1'b1; end
    end else if (ex_mem_mem_re_i || ex_mem_mem_we_i) begin
      e_wb_we <= 1'b0;
      if (!is_mis(ex_mem_size_i, ex_mem_op_c_i)) begin
        t_addr <= ex_mem_op_c_i; t_wdata <= ex_mem_wdata_i; t_size <= ex_mem_size_i;
        t_uns <= ex_mem_unsigned_i; t_store <= ex_mem_mem_we_i && !ex_mem_mem_re_i;
        t_we <= ex_mem_reg_we_i; t_waddr <= ex_mem_reg_waddr_i;
        if (dbus_gnt_i) m_await_rsp <= 1'b1;
        else            m_await_gnt <= 1'b1;
      end
    end else begin
      e_wb_data <= ex_mem_op_c_i; e_wb_waddr <= ex_mem_reg_waddr_i; e_wb_we <= ex_mem_reg_we_i;
    end
  end

  logic        x_req, x_we, x_stall, x_mis;
  logic [31:0] x_addr, x_wd;
  logic [3:0]  x_be;

  always_comb begin
    x_req = 1'b0; x_we = 1'b0; x_stall = 1'b0; x_mis = 1'b0;
    x_addr = 32'h0; x_wd = 32'h0; x_be = 4'h0;
    if (rst_n) begin
      if (m_await_rsp) begin
        x_stall = !dbus_rvalid_i;
      end else if (m_await_gnt) begin
        x_req = 1'b1; x_stall = 1'b1; x_we = t_store;
        x_addr = t_addr & 32'hFFFFFFFC;
        x_be = m_be(t_size, t_addr);
        x_wd = m_lanes(t_size, t_wdata);
      end else if (ex_mem_mem_re_i || ex_mem_mem_we_i) begin
        if (is_mis(ex_mem_size_i, ex_mem_op_c_i)) begin
          x_mis = 1'b1;
        end else begin
          x_req = 1'b1; x_stall = 1'b1; x_we = ex_mem_mem_we_i && !ex_mem_mem_re_i;
          x_addr = ex_mem_op_c_i & 32'hFFFFFFFC;
          x_be = m_be(ex_mem_size_i, ex_mem_op_c_i);
          x_wd = m_lanes(ex_mem_size_i, ex_mem_wdata_i);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("dbus_req", 32'(dbus_req_o), 32'(x_req));
    chk("dbus_we", 32'(dbus_we_o), 32'(x_we));
    chk("dbus_addr", dbus_addr_o, x_addr);
    chk("dbus_be", 32'(dbus_be_o), 32'(x_be));
    chk("dbus_wdata", dbus_wdata_o, x_wd);
    chk("mem_stall", 32'(mem_stall_o), 32'(x_stall));
    chk("mem_misaligned", 32'(mem_misaligned_o), 32'(x_mis));
    chk("wb_data", wb_data_o, e_wb_data);
    chk("wb_waddr", 32'(wb_waddr_o), 32'(e_wb_waddr));
    chk("wb_we", 32'(wb_we_o), 32'(e_wb_we));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #4;
    if (dbus_req_o) req_cnt++;
    if (mem_stall_o) stall_cnt++;
    if (mem_misaligned_o) mis_cnt++;
  endtask

  task automatic clr_cnt();
    req_cnt = 0; stall_cnt = 0; mis_cnt = 0;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [4:0] wa, input logic rwe,
                        input logic re, input logic we, input logic [31:0] wd,
                        input logic [1:0] sz, input logic uns);
    ex_mem_op_c_i = a; ex_mem_reg_waddr_i = wa; ex_mem_reg_we_i = rwe;
    ex_mem_mem_re_i = re; ex_mem_mem_we_i = we; ex_mem_wdata_i = wd;
    ex_mem_size_i = sz; ex_mem_unsigned_i = uns;
  endtask

  task automatic bus(input logic g, input logic rv, input logic [31:0] rd);
    dbus_gnt_i = g; dbus_rvalid_i = rv; dbus_rdata_i = rd;
  endtask

  task automatic nop();
    set_op(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 1'b0);
    bus(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset with a load on the inputs: outputs must still read zero.
    set_op(32'h1000, 5'd1, 1'b1, 1'b1, 1'b0, 32'h0, 2'b10, 1'b0);
    tick(); tick(); settle();
    chk("reset_req", 32'(dbus_req_o), 32'd0);
    chk("reset_stall", 32'(mem_stall_o), 32'd0);
    chk("reset_wb_we", 32'(wb_we_o), 32'd0);
    tick(); rst_n = 1'b1; nop(); settle();

    // ALU op with a stray response in IDLE
    tick(); clr_cnt();
    set_op(32'hDEADBEEF, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 2'b10, 1'b0);
    bus(1'b0, 1'b1, 32'h55555555); settle();
    tick(); nop(); settle();
    chk("alu_wb_data", wb_data_o, 32'hDEADBEEF);
    chk("alu_wb_waddr", 32'(wb_waddr_o), 32'd5);
    chk("alu_wb_we", 32'(wb_we_o), 32'd1);
    chk("alu_stall_cnt", 32'(stall_cnt), 32'd0);

    // Word load, immediate grant, response two cycles later
    tick(); clr_cnt();
    set_op(32'h1004, 5'd7, 1'b1, 1'b1, 1'b0, 32'h0, 2'b10, 1'b0);
    bus(1'b1, 1'b0, 32'h0); settle();
    chk("wl_addr", dbus_addr_o, 32'h1004);
    chk("wl_be", 32'(dbus_be_o), 32'hF);
    tick(); bus(1'b0, 1'b0, 32'h0); settle();
    tick(); bus(1'b0, 1'b1, 32'hCAFEF00D); settle();
    tick(); nop(); settle();
    chk("wl_wb_data", wb_data_o, 32'hCAFEF00D);
    chk("wl_wb_waddr", 32'(wb_waddr_o), 32'd7);
    chk("wl_stall_cnt", 32'(stall_cnt), 32'd2);

    // Signed byte load, grant delayed three cycles
    tick(); clr_cnt();
    set_op(32'h2003, 5'd9, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
    bus(1'b0, 1'b0, 32'h0); settle();
    for (int i = 0; i < 2; i++) begin tick(); bus(1'b0, 1'b0, 32'h0); settle(); end
    tick(); bus(1'b1, 1'b0, 32'h0); settle();
    chk("sb_addr", dbus_addr_o, 32'h2000);
    chk("sb_be", 32'(dbus_be_o), 32'h8);
    tick(); bus(1'b0, 1'b0, 32'h0); settle();
    tick(); bus(1'b0, 1'b1, 32'h80000000); settle();
    tick(); nop(); settle();
    chk("sb_wb_data", wb_data_o, 32'hFFFFFF80);
    chk("sb_req_cnt", 32'(req_cnt), 32'd4);

    // Unsigned byte load; grant and response together in REQ count as grant only
    tick();
    set_op(32'h2003, 5'd9, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
    bus(1'b0, 1'b0, 32'h0); settle();
    tick(); bus(1'b1, 1'b1, 32'hDEADDEAD); settle();
    tick(); bus(1'b0, 1'b1, 32'h80000000); settle();
    tick(); nop(); settle();
    chk("ub_wb_data", wb_data_o, 32'h00000080);

    // Half store at 0x3002
    tick();
    set_op(32'h3002, 5'd3, 1'b1, 1'b0, 1'b1, 32'h00001234, 2'b01, 1'b0);
    bus(1'b1, 1'b0, 32'h0); settle();
    chk("hs_we", 32'(dbus_we_o), 32'd1);
    chk("hs_be", 32'(dbus_be_o), 32'hC);
    chk("hs_wdata", dbus_wdata_o, 32'h12341234);
    tick(); bus(1'b0, 1'b1, 32'hFFFFFFFF); settle();
    tick(); nop(); settle();
    chk("hs_wb_we", 32'(wb_we_o), 32'd0);

    // Both enables set: treated as a load
    tick();
    set_op(32'h4000, 5'd4, 1'b1, 1'b1, 1'b1, 32'hAAAAAAAA, 2'b10, 1'b0);
    bus(1'b1, 1'b0, 32'h0); settle();
    chk("rw_dbus_we", 32'(dbus_we_o), 32'd0);
    tick(); bus(1'b0, 1'b1, 32'h11223344); settle();
    tick(); nop(); settle();
    chk("rw_wb_data", wb_data_o, 32'h11223344);

    // Signed half load from the upper half
    tick();
    set_op(32'h5002, 5'd10, 1'b1, 1'b1, 1'b0, 32'h0, 2'b01, 1'b0);
    bus(1'b1, 1'b0, 32'h0); settle();
    tick(); bus(1'b0, 1'b1, 32'hBEEF0000); settle();
    tick(); nop(); settle();
    chk("sh_wb_data", wb_data_o, 32'hFFFFBEEF);

    // Misaligned word load, preceded by an ALU write so the bubble is visible
    tick();
    set_op(32'h77, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0, 2'b10, 1'b0); settle();
    tick(); clr_cnt();
    set_op(32'h1002, 5'd6, 1'b1, 1'b1, 1'b0, 32'h0, 2'b10, 1'b0); settle();
    chk("mis_pulse", 32'(mem_misaligned_o), 32'd1);
    chk("mis_prev_wb_we", 32'(wb_we_o), 32'd1);
    tick(); nop(); settle();
    chk("mis_wb_we", 32'(wb_we_o), 32'd0);
    chk("mis_cnt", 32'(mis_cnt), 32'd1);
    chk("mis_req_cnt", 32'(req_cnt), 32'd0);

    // Reset while waiting for the response; the late response must be ignored
    tick();
    set_op(32'h1008, 5'd8, 1'b1, 1'b1, 1'b0, 32'h0, 2'b10, 1'b0);
    bus(1'b1, 1'b0, 32'h0); settle();
    tick(); bus(1'b0, 1'b0, 32'h0); settle();
    tick(); rst_n = 1'b0; settle();
    chk("rst_stall", 32'(mem_stall_o), 32'd0);
    chk("rst_addr", dbus_addr_o, 32'h0);
    tick(); rst_n = 1'b1; nop(); bus(1'b0, 1'b1, 32'h12345678); settle();
    chk("late_rvalid_stall", 32'(mem_stall_o), 32'd0);
    tick(); nop(); settle();
    chk("late_rvalid_wb_we", 32'(wb_we_o), 32'd0);
    chk("late_rvalid_wb_data", wb_data_o, 32'h0);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
